// File: rtl/rca_config_pkg.sv
// rtl/rca_config_pkg.sv - shared profiler parameters, scan FSM states and mapped-slot type
// Contents:
//   CFG_* default profiler/RCA parameters
//   scan_state_t  : sequencing FSM states
//   mapped_slot_t : one mapped-loop table slot {addr, valid}
package rca_config;

  localparam int CFG_XLEN                  = 32;
  localparam int CFG_NUM_PROFILER_ENTRIES  = 8;
  localparam int CFG_MAX_TAKEN_COUNT       = 64;
  localparam int CFG_TAKEN_COUNT_THRESHOLD = 32;
  localparam int CFG_NUM_RCAS              = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_DRAIN,
    ST_DECIDE,
    ST_OFFER,
    ST_RELEASE
  } scan_state_t;

  typedef struct packed {
    logic [CFG_XLEN-1:0] addr;
    logic                valid;
  } mapped_slot_t;

endpackage

// File: rtl/rca_mapped_table.sv
// rtl/rca_mapped_table.sv - table of loop addresses already mapped to an RCA
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   wr_en        : write wr_addr into the slot at the write pointer, then advance it
//   wr_addr      : address to record
//   flush        : invalidate every slot and rewind the pointer (beats wr_en)
//   lookup_addr  : address to test
//   hit          : lookup_addr matches a valid slot (combinational)
module rca_mapped_table
  import rca_config::*;
#(
  parameter int NUM_RCAS = CFG_NUM_RCAS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CFG_XLEN-1:0] wr_addr,
  input  logic                flush,
  input  logic [CFG_XLEN-1:0] lookup_addr,
  output logic                hit
);

  localparam int PW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_RCAS - 1);

  mapped_slot_t   slots [NUM_RCAS];
  logic [PW-1:0]  wr_ptr;

  // Pointer wraps so the oldest mapping is the one overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        slots[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        slots[i].valid <= 1'b0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      slots[wr_ptr].addr  <= wr_addr;
      slots[wr_ptr].valid <= 1'b1;
      wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (slots[i].valid && (slots[i].addr == lookup_addr)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rca_profile_scan_ctrl.sv
// rtl/rca_profile_scan_ctrl.sv - locks the profile cache, scans it and offers the hottest unmapped loop
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   profiler_exception       : threshold-crossed pulse that starts a scan
//   profiler_lock            : freezes the profile cache while a scan is in flight
//   rd_en, rd_index          : entry read request (response one cycle later)
//   rd_addr, rd_entry_valid,
//   rd_taken_count           : read response
//   sel_valid, sel_ready     : selection handshake to the RCA configuration manager
//   sel_addr, sel_index,
//   sel_count                : selected entry, stable while sel_valid
//   rca_flush                : clear the mapped-loop table
//   busy                     : controller is not idle
module rca_profile_scan_ctrl
  import rca_config::*;
#(
  parameter int XLEN                  = CFG_XLEN,
  parameter int NUM_PROFILER_ENTRIES  = CFG_NUM_PROFILER_ENTRIES,
  parameter int MAX_TAKEN_COUNT       = CFG_MAX_TAKEN_COUNT,
  parameter int TAKEN_COUNT_THRESHOLD = CFG_TAKEN_COUNT_THRESHOLD,
  parameter int NUM_RCAS              = CFG_NUM_RCAS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    profiler_exception,
  output logic                                    profiler_lock,
  output logic                                    rd_en,
  output logic [$clog2(NUM_PROFILER_ENTRIES)-1:0] rd_index,
  input  logic [XLEN-1:0]                         rd_addr,
  input  logic                                    rd_entry_valid,
  input  logic [$clog2(MAX_TAKEN_COUNT)-1:0]      rd_taken_count,
  output logic                                    sel_valid,
  input  logic                                    sel_ready,
  output logic [XLEN-1:0]                         sel_addr,
  output logic [$clog2(NUM_PROFILER_ENTRIES)-1:0] sel_index,
  output logic [$clog2(MAX_TAKEN_COUNT)-1:0]      sel_count,
  input  logic                                    rca_flush,
  output logic                                    busy
);

  localparam int IW = $clog2(NUM_PROFILER_ENTRIES);
  localparam int CW = $clog2(MAX_TAKEN_COUNT);
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_PROFILER_ENTRIES - 1);
  localparam logic [CW-1:0] THRESHOLD  = CW'(TAKEN_COUNT_THRESHOLD);

  scan_state_t     state;
  scan_state_t     state_next;
  logic            pending;
  logic [IW-1:0]   scan_idx;
  logic            resp_valid;
  logic [IW-1:0]   resp_index;
  logic            best_valid;
  logic [XLEN-1:0] best_addr;
  logic [IW-1:0]   best_index;
  logic [CW-1:0]   best_count;
  logic            mapped_hit;
  logic            candidate;
  logic            handshake;

  rca_mapped_table #(
    .NUM_RCAS (NUM_RCAS)
  ) u_mapped_table (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (handshake),
    .wr_addr     (sel_addr),
    .flush       (rca_flush),
    .lookup_addr (rd_addr),
    .hit         (mapped_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops the
  // lock and the offer without waiting for a clock edge.
  always_comb begin
    state_next    = state;
    profiler_lock = 1'b0;
    rd_en         = 1'b0;
    sel_valid     = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (profiler_exception || pending) begin
          state_next = ST_LOCK;
        end
      end
      ST_LOCK: begin
        profiler_lock = 1'b1;
        state_next    = ST_SCAN;
      end
      ST_SCAN: begin
        profiler_lock = 1'b1;
        rd_en         = 1'b1;
        if (scan_idx == LAST_INDEX) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        profiler_lock = 1'b1;
        state_next    = ST_DECIDE;
      end
      ST_DECIDE: begin
        profiler_lock = 1'b1;
        state_next    = best_valid ? ST_OFFER : ST_RELEASE;
      end
      ST_OFFER: begin
        profiler_lock = 1'b1;
        sel_valid     = 1'b1;
        if (sel_ready) begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign handshake = sel_valid && sel_ready;
  assign rd_index  = scan_idx;

  // IDLE consumes any pending request immediately, so clearing it there
  // never loses one; pulses while busy collapse into a single bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (state == ST_IDLE) begin
      pending <= 1'b0;
    end else if (profiler_exception) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx   <= '0;
      resp_valid <= 1'b0;
      resp_index <= '0;
    end else begin
      if (state == ST_LOCK) begin
        scan_idx <= '0;
      end else if (state == ST_SCAN) begin
        scan_idx <= (scan_idx == LAST_INDEX) ? '0 : scan_idx + 1'b1;
      end
      resp_valid <= rd_en;
      resp_index <= scan_idx;
    end
  end

  assign candidate = resp_valid && rd_entry_valid && (rd_taken_count >= THRESHOLD) && !mapped_hit;

  // Strict greater-than keeps the earliest (lowest-index) entry on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_valid <= 1'b0;
      best_addr  <= '0;
      best_index <= '0;
      best_count <= '0;
    end else if (state == ST_LOCK) begin
      best_valid <= 1'b0;
      best_count <= '0;
    end else if (candidate && (!best_valid || (rd_taken_count > best_count))) begin
      best_valid <= 1'b1;
      best_addr  <= rd_addr;
      best_index <= resp_index;
      best_count <= rd_taken_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_addr  <= '0;
      sel_index <= '0;
      sel_count <= '0;
    end else if ((state == ST_DECIDE) && best_valid) begin
      sel_addr  <= best_addr;
      sel_index <= best_index;
      sel_count <= best_count;
    end
  end

endmodule

// File: tb/tb_rca_profile_scan_ctrl.sv
// tb/tb_rca_profile_scan_ctrl.sv - self-checking bench for rca_profile_scan_ctrl
module tb_rca_profile_scan_ctrl;

  localparam int N    = 8;
  localparam int NRCA = 4;

  logic        clk;
  logic        rst;
  logic        profiler_exception;
  logic        profiler_lock;
  logic        rd_en;
  logic [2:0]  rd_index;
  logic [31:0] rd_addr;
  logic        rd_entry_valid;
  logic [5:0]  rd_taken_count;
  logic        sel_valid;
  logic        sel_ready;
  logic [31:0] sel_addr;
  logic [2:0]  sel_index;
  logic [5:0]  sel_count;
  logic        rca_flush;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_addr  [N];
  bit          mem_valid [N];
  logic [5:0]  mem_count [N];
  logic [31:0] mapped_q [$];

  rca_profile_scan_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .profiler_exception (profiler_exception),
    .profiler_lock      (profiler_lock),
    .rd_en              (rd_en),
    .rd_index           (rd_index),
    .rd_addr            (rd_addr),
    .rd_entry_valid     (rd_entry_valid),
    .rd_taken_count     (rd_taken_count),
    .sel_valid          (sel_valid),
    .sel_ready          (sel_ready),
    .sel_addr           (sel_addr),
    .sel_index          (sel_index),
    .sel_count          (sel_count),
    .rca_flush          (rca_flush),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Profile cache: registered read, data valid the cycle after the request.
  always @(posedge clk) begin
    rd_addr        <= mem_addr[rd_index];
    rd_entry_valid <= mem_valid[rd_index];
    rd_taken_count <= mem_count[rd_index];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    foreach (mapped_q[i]) if (mapped_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Hottest qualifying unmapped entry; the first one met wins ties.
  task automatic model_pick(output bit found, output int idx);
    int best;
    found = 1'b0;
    idx   = 0;
    best  = -1;
    for (int i = 0; i < N; i++) begin
      if (mem_valid[i] && mem_count[i] >= 32 && !is_mapped(mem_addr[i]) && int'(mem_count[i]) > best) begin
        best  = int'(mem_count[i]);
        idx   = i;
        found = 1'b1;
      end
    end
  endtask

  task automatic model_accept(input logic [31:0] a, input bit flush);
    if (flush) begin
      mapped_q.delete();
    end else begin
      mapped_q.push_back(a);
      if (mapped_q.size() > NRCA) void'(mapped_q.pop_front());
    end
  endtask

  task automatic set_cold();
    for (int i = 0; i < N; i++) begin
      mem_addr[i]  = ($urandom() & 32'hFFFF_F000) | 32'h0000_0800 | (i << 4);
      mem_valid[i] = 1'($urandom_range(0, 1));
      mem_count[i] = 6'($urandom_range(0, 31));
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] a, input logic [5:0] c);
    mem_addr[i]  = a;
    mem_valid[i] = 1'b1;
    mem_count[i] = c;
  endtask

  // Called on a negedge. pulse=0 means a pending request restarts the scan.
  task automatic run_scan(input bit pulse, input int bp, input bit ready_early,
                          input bit exc_in_offer, input bit flush_on_accept);
    bit   found;
    int   idx;
    int   cyc;
    int   scan_exp;
    logic [41:0] exp_sel;
    model_pick(found, idx);
    if (pulse) begin
      profiler_exception = 1'b1;
      @(negedge clk);
      profiler_exception = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk("lock_entry", {62'd0, profiler_lock, busy}, 64'd3);
    sel_ready = ready_early;
    cyc = 1;
    scan_exp = 0;
    while (!(sel_valid || !profiler_lock) && cyc < 40) begin
      if (rd_en) begin
        chk("rd_index_seq", 64'(rd_index), 64'(scan_exp));
        scan_exp++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("scan_reads", 64'(scan_exp), 64'(N));
    chk("decision_latency", 64'(cyc), 64'(N + 4));
    if (found) begin
      exp_sel = {1'b1, 3'(idx), mem_count[idx], mem_addr[idx]};
      chk("offer", {sel_valid, sel_index, sel_count, sel_addr}, 64'(exp_sel));
      for (int k = 0; k < bp; k++) begin
        profiler_exception = exc_in_offer && (k == 1);
        @(negedge clk);
        chk("offer_stable", {sel_valid, sel_index, sel_count, sel_addr}, 64'(exp_sel));
      end
      profiler_exception = 1'b0;
      sel_ready = 1'b1;
      rca_flush = flush_on_accept;
      @(negedge clk);
      sel_ready = 1'b0;
      rca_flush = 1'b0;
      model_accept(mem_addr[idx], flush_on_accept);
      chk("release_after_accept", {61'd0, profiler_lock, sel_valid, busy}, 64'd1);
    end else begin
      chk("release_no_candidate", {61'd0, profiler_lock, sel_valid, busy}, 64'd1);
      sel_ready = 1'b0;
    end
    @(negedge clk);
    chk("idle_after_release", {62'd0, busy, profiler_lock}, 64'd0);
  endtask

  initial begin
    int   bp;
    bit   seen_busy;
    rst = 1'b1;
    profiler_exception = 1'b0;
    sel_ready = 1'b0;
    rca_flush = 1'b0;
    set_cold();
    @(negedge clk);
    chk("rst_lock", 64'(profiler_lock), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_index", 64'(rd_index), 64'd0);
    chk("rst_sel_valid", 64'(sel_valid), 64'd0);
    chk("rst_sel_regs", {sel_index, sel_count, sel_addr}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single hot entry (index 6 is the runner-up), ready held from the start.
    set_cold();
    set_entry(3, 32'h100, 6'd40);
    set_entry(6, 32'h600, 6'd33);
    run_scan(1, 0, 1, 0, 0);
    chk("hot_sel_addr", 64'(sel_addr), 64'h100);
    // Already mapped: runner-up, then nothing left.
    run_scan(1, 0, 0, 0, 0);
    chk("mapped_skip_index", 64'(sel_index), 64'd6);
    run_scan(1, 0, 0, 0, 0);

    // Tie with backpressure and an exception during OFFER.
    set_cold();
    set_entry(2, 32'h200, 6'd50);
    set_entry(5, 32'h500, 6'd50);
    run_scan(1, 5, 0, 1, 0);
    chk("tie_index", 64'(sel_index), 64'd2);
    run_scan(0, 0, 0, 0, 0);
    chk("pending_rescan_index", 64'(sel_index), 64'd5);

    // Flush makes everything selectable again.
    rca_flush = 1'b1;
    @(negedge clk);
    rca_flush = 1'b0;
    mapped_q.delete();
    run_scan(1, 0, 0, 0, 0);

    // Wrap: five distinct accepts evict the first.
    rca_flush = 1'b1;
    @(negedge clk);
    rca_flush = 1'b0;
    mapped_q.delete();
    set_cold();
    for (int i = 0; i < 5; i++) set_entry(i, 32'h1000 + 32'(i) * 32'h40, 6'(60 - 5 * i));
    for (int s = 0; s < 7; s++) run_scan(1, $urandom_range(0, 2), 0, 0, 0);

    // Flush coinciding with the handshake wins.
    run_scan(1, 1, 0, 0, 1);
    run_scan(1, 0, 0, 0, 0);

    // Randomised contents, each scanned a few times.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) begin
        mem_addr[i]  = ($urandom() & 32'hFFFF_F000) | 32'h0000_0400 | (i << 4);
        mem_valid[i] = ($urandom_range(0, 3) != 0);
        mem_count[i] = 6'($urandom_range(0, 63));
      end
      for (int r = 0; r < 3; r++) begin
        bp = $urandom_range(0, 3);
        run_scan(1, bp, 0, 0, ($urandom_range(0, 4) == 0));
      end
    end

    // Asynchronous reset mid-scan with a pending request.
    set_cold();
    set_entry(1, 32'h7700, 6'd63);
    profiler_exception = 1'b1;
    @(negedge clk);
    profiler_exception = 1'b0;
    repeat (3) @(negedge clk);
    profiler_exception = 1'b1;
    @(negedge clk);
    profiler_exception = 1'b0;
    chk("scan_before_reset", {62'd0, rd_en, profiler_lock}, 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {61'd0, profiler_lock, busy, sel_valid}, 64'd0);
    chk("async_rst_rd_en", 64'(rd_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mapped_q.delete();
    seen_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    chk("pending_cleared_by_reset", 64'(seen_busy), 64'd0);
    run_scan(1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
